// File: rtl/fir_filter_mac.sv
// ---------------------------------------------------------------------------
// fir_filter_mac
//
// Single-multiplier, time-multiplexed FIR filter. One accepted input sample
// produces one filtered output sample TAPS+2 cycles later. The coefficient
// memory can be rewritten at run time while the block is idle, and the output
// is rounded (half toward +inf) and saturated to the sample width.
//
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous, active-high reset
//   audio_in        signed input sample
//   valid_in        sample strobe, accepted only while ready_out is high
//   coef_we         coefficient write strobe, accepted only while ready_out is high
//   coef_addr       tap index of the coefficient write
//   coef_data       signed coefficient value
//   filtered_audio  signed filtered sample, held until the next data_ready
//   data_ready      one-cycle pulse, filtered_audio carries a new result
//   ready_out       high while idle; a sample or coefficient write can be taken
//   overrun_out     one-cycle pulse: a valid_in or coef_we was dropped while busy
//   sat_out         one-cycle pulse with data_ready when the result was clipped
// ---------------------------------------------------------------------------
module fir_filter_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 32,
    parameter int SHIFT      = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic signed [DATA_WIDTH-1:0]  audio_in,
    input  logic                          valid_in,
    input  logic                          coef_we,
    input  logic [$clog2(TAPS)-1:0]       coef_addr,
    input  logic signed [COEF_WIDTH-1:0]  coef_data,
    output logic signed [DATA_WIDTH-1:0]  filtered_audio,
    output logic                          data_ready,
    output logic                          ready_out,
    output logic                          overrun_out,
    output logic                          sat_out
);

    localparam int IDX_WIDTH  = $clog2(TAPS);
    localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS);

    // Unity gain coefficient: 1.0 in the coefficient's fixed-point format.
    localparam logic signed [COEF_WIDTH-1:0] COEF_IMPULSE = COEF_WIDTH'(1) << SHIFT;

    // Rounding bias and clip limits live one bit wider than the accumulator so
    // that adding the bias can never wrap.
    localparam logic signed [ACC_WIDTH:0] ROUND_BIAS =
        (SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [ACC_WIDTH:0] CLIP_MAX =
        {{(ACC_WIDTH + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] CLIP_MIN =
        {{(ACC_WIDTH + 2 - DATA_WIDTH){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t                        state_q, state_d;
    logic [IDX_WIDTH-1:0]          idx_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic signed [DATA_WIDTH-1:0]  delayLine_q [TAPS];
    logic signed [COEF_WIDTH-1:0]  coefMem_q [TAPS];
    logic signed [DATA_WIDTH-1:0]  filtered_q;
    logic                          dataReady_q;
    logic                          overrun_q;
    logic                          sat_q;

    logic                          acceptSample;
    logic                          acceptCoef;
    logic                          addrInRange;
    logic                          lastTap;
    logic signed [PROD_WIDTH-1:0]  product;
    logic signed [ACC_WIDTH-1:0]   productExt;
    logic signed [ACC_WIDTH:0]     accExt;
    logic signed [ACC_WIDTH:0]     rounded;
    logic signed [ACC_WIDTH:0]     shifted;
    logic                          clipHigh;
    logic                          clipLow;
    logic signed [DATA_WIDTH-1:0]  outSample;

    assign addrInRange = ({1'b0, coef_addr} < (IDX_WIDTH+1)'(TAPS));
    assign lastTap     = (idx_q == IDX_WIDTH'(TAPS - 1));

    // Full-precision product, sign-extended to the accumulator width.
    assign product    = coefMem_q[idx_q] * delayLine_q[idx_q];
    assign productExt = {{IDX_WIDTH{product[PROD_WIDTH-1]}}, product};

    // Round half toward +inf, arithmetic shift, then clip to the sample range.
    assign accExt   = {acc_q[ACC_WIDTH-1], acc_q};
    assign rounded  = accExt + ROUND_BIAS;
    assign shifted  = rounded >>> SHIFT;
    assign clipHigh = (shifted > CLIP_MAX);
    assign clipLow  = (shifted < CLIP_MIN);

    always_comb begin
        outSample = shifted[DATA_WIDTH-1:0];
        if (clipHigh) begin
            outSample = OUT_MAX;
        end else if (clipLow) begin
            outSample = OUT_MIN;
        end
    end

    // Next-state logic. Samples and coefficient writes are only taken in IDLE;
    // a write together with a sample is applied before the MAC pass reads it.
    always_comb begin
        state_d      = state_q;
        acceptSample = 1'b0;
        acceptCoef   = 1'b0;
        case (state_q)
            IDLE: begin
                acceptCoef = coef_we && addrInRange;
                if (valid_in) begin
                    acceptSample = 1'b1;
                    state_d      = MAC;
                end
            end
            MAC: begin
                if (lastTap) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: delay line, coefficient memory, accumulator and output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            idx_q       <= '0;
            acc_q       <= '0;
            filtered_q  <= '0;
            dataReady_q <= 1'b0;
            overrun_q   <= 1'b0;
            sat_q       <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                delayLine_q[i] <= '0;
                coefMem_q[i]   <= (i == 0) ? COEF_IMPULSE : '0;
            end
        end else begin
            dataReady_q <= 1'b0;
            sat_q       <= 1'b0;
            overrun_q   <= (state_q != IDLE) && (valid_in || coef_we);

            if (acceptCoef) begin
                coefMem_q[coef_addr] <= coef_data;
            end

            if (acceptSample) begin
                delayLine_q[0] <= audio_in;
                for (int i = 1; i < TAPS; i++) begin
                    delayLine_q[i] <= delayLine_q[i-1];
                end
                idx_q <= '0;
                acc_q <= '0;
            end

            if (state_q == MAC) begin
                acc_q <= acc_q + productExt;
                idx_q <= idx_q + IDX_WIDTH'(1);
            end else if (state_q == OUT) begin
                filtered_q  <= outSample;
                dataReady_q <= 1'b1;
                sat_q       <= clipHigh || clipLow;
            end
        end
    end

    assign filtered_audio = filtered_q;
    assign data_ready     = dataReady_q;
    assign ready_out      = (state_q == IDLE);
    assign overrun_out    = overrun_q;
    assign sat_out        = sat_q;

endmodule

// File: tb/tb_fir_filter_mac.sv
// ---------------------------------------------------------------------------
// tb_fir_filter_mac
//
// Self-checking bench for fir_filter_mac. Two instances share clock and reset:
// dutA uses the default 32-tap configuration (latency and pass-through), dutB
// uses 4 taps for the arithmetic, rounding, saturation, overrun and reset
// scenarios. dutB results are compared against a plain-arithmetic model of the
// filter (sum of coefficient*sample products, round, clip).
// ---------------------------------------------------------------------------
module tb_fir_filter_mac;

    localparam int TAPS_A = 32;
    localparam int TAPS_B = 4;
    localparam int SH     = 8;

    logic clk;
    logic rst;

    // dutA (32 taps)
    logic signed [15:0] audioA;
    logic               validA;
    logic               weA;
    logic [4:0]         addrA;
    logic signed [15:0] dataA;
    logic signed [15:0] filtA;
    logic               dataReadyA;
    logic               readyA;
    logic               overrunA;
    logic               satA;

    // dutB (4 taps)
    logic signed [15:0] audioB;
    logic               validB;
    logic               weB;
    logic [1:0]         addrB;
    logic signed [15:0] dataB;
    logic signed [15:0] filtB;
    logic               dataReadyB;
    logic               readyB;
    logic               overrunB;
    logic               satB;

    int errors;
    int checks;

    int coefM [TAPS_B];
    int delayM [TAPS_B];

    fir_filter_mac #(
        .DATA_WIDTH(16), .COEF_WIDTH(16), .TAPS(TAPS_A), .SHIFT(SH)
    ) dutA (
        .clk_in(clk), .rst_in(rst),
        .audio_in(audioA), .valid_in(validA),
        .coef_we(weA), .coef_addr(addrA), .coef_data(dataA),
        .filtered_audio(filtA), .data_ready(dataReadyA),
        .ready_out(readyA), .overrun_out(overrunA), .sat_out(satA)
    );

    fir_filter_mac #(
        .DATA_WIDTH(16), .COEF_WIDTH(16), .TAPS(TAPS_B), .SHIFT(SH)
    ) dutB (
        .clk_in(clk), .rst_in(rst),
        .audio_in(audioB), .valid_in(validB),
        .coef_we(weB), .coef_addr(addrB), .coef_data(dataB),
        .filtered_audio(filtB), .data_ready(dataReadyB),
        .ready_out(readyB), .overrun_out(overrunB), .sat_out(satB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: impulse coefficients and an empty delay line after reset.
    function automatic void modelReset();
        for (int i = 0; i < TAPS_B; i++) begin
            coefM[i]  = (i == 0) ? (1 << SH) : 0;
            delayM[i] = 0;
        end
    endfunction

    // Push one sample into the model and return the rounded, clipped output.
    function automatic int modelStep(input int sample, output bit satExp);
        longint acc;
        longint r;
        for (int i = TAPS_B - 1; i > 0; i--) begin
            delayM[i] = delayM[i-1];
        end
        delayM[0] = sample;
        acc = 0;
        for (int i = 0; i < TAPS_B; i++) begin
            acc += longint'(coefM[i]) * longint'(delayM[i]);
        end
        r = (acc + (longint'(1) << (SH - 1))) >>> SH;
        satExp = 1'b0;
        if (r > 32767) begin
            r = 32767;
            satExp = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            satExp = 1'b1;
        end
        return int'(r);
    endfunction

    task automatic applyReset();
        validA = 1'b0; weA = 1'b0; addrA = '0; dataA = '0; audioA = '0;
        validB = 1'b0; weB = 1'b0; addrB = '0; dataB = '0; audioB = '0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        modelReset();
    endtask

    task automatic writeCoefB(input int addr, input int value);
        weB   = 1'b1;
        addrB = addr[1:0];
        dataB = value[15:0];
        @(posedge clk);
        #1 weB = 1'b0;
        coefM[addr] = value;
    endtask

    // Present a sample to dutB and wait (bounded) for its result. Called just
    // after a clock edge; returns one time unit after the data_ready edge so a
    // following call presents its sample in the data_ready cycle.
    task automatic runSampleB(input int sample, output int got, output bit sat, output int lat);
        bit done;
        audioB = sample[15:0];
        validB = 1'b1;
        @(posedge clk);
        #1;
        validB = 1'b0;
        weB    = 1'b0;
        got = 0; sat = 1'b0; lat = -1; done = 1'b0;
        for (int e = 1; e <= TAPS_B + 8; e++) begin
            if (!done) begin
                @(posedge clk);
                #1;
                if (dataReadyB) begin
                    done = 1'b1;
                    lat  = e;
                    got  = int'(filtB);
                    sat  = satB;
                end
            end
        end
    endtask

    task automatic runSampleA(input int sample, output int got, output int lat);
        bit done;
        audioA = sample[15:0];
        validA = 1'b1;
        @(posedge clk);
        #1;
        validA = 1'b0;
        got = 0; lat = -1; done = 1'b0;
        for (int e = 1; e <= TAPS_A + 8; e++) begin
            if (!done) begin
                @(posedge clk);
                #1;
                if (dataReadyA) begin
                    done = 1'b1;
                    lat  = e;
                    got  = int'(filtA);
                end
            end
        end
    endtask

    task automatic test_reset();
        applyReset();
        checks++; if (readyA !== 1'b1) begin errors++; $display("[TB] FAIL resetReadyA: got %b expected 1", readyA); end
        checks++; if (dataReadyA !== 1'b0) begin errors++; $display("[TB] FAIL resetDataReadyA: got %b expected 0", dataReadyA); end
        checks++; if (filtA !== 16'sd0) begin errors++; $display("[TB] FAIL resetFiltA: got %0d expected 0", filtA); end
        checks++; if (readyB !== 1'b1) begin errors++; $display("[TB] FAIL resetReadyB: got %b expected 1", readyB); end
        checks++; if ({dataReadyB, overrunB, satB} !== 3'b000) begin errors++; $display("[TB] FAIL resetPulsesB: got %b expected 000", {dataReadyB, overrunB, satB}); end
        checks++; if (filtB !== 16'sd0) begin errors++; $display("[TB] FAIL resetFiltB: got %0d expected 0", filtB); end
    endtask

    task automatic test_default_latency();
        int got;
        int lat;
        int inputs [2] = '{1000, -500};
        applyReset();
        for (int i = 0; i < 2; i++) begin
            runSampleA(inputs[i], got, lat);
            checks++; if (lat !== TAPS_A + 1) begin errors++; $display("[TB] FAIL latencyA[%0d]: got %0d expected %0d", i, lat, TAPS_A + 1); end
            checks++; if (got !== inputs[i]) begin errors++; $display("[TB] FAIL passThroughA[%0d]: got %0d expected %0d", i, got, inputs[i]); end
            checks++; if (satA !== 1'b0) begin errors++; $display("[TB] FAIL satA[%0d]: got %b expected 0", i, satA); end
        end
    endtask

    // Four equal unity taps give a running sum; samples run back to back.
    task automatic test_back_to_back();
        int got;
        int lat;
        bit sat;
        bit satExp;
        int exp;
        int inputs [4] = '{100, 200, 300, 400};
        int sums [4]   = '{100, 300, 600, 1000};
        applyReset();
        for (int i = 0; i < TAPS_B; i++) writeCoefB(i, 256);
        for (int i = 0; i < 4; i++) begin
            exp = modelStep(inputs[i], satExp);
            runSampleB(inputs[i], got, sat, lat);
            checks++; if (lat !== TAPS_B + 1) begin errors++; $display("[TB] FAIL b2bLatency[%0d]: got %0d expected %0d", i, lat, TAPS_B + 1); end
            checks++; if (got !== sums[i]) begin errors++; $display("[TB] FAIL b2bSum[%0d]: got %0d expected %0d", i, got, sums[i]); end
            checks++; if (sat !== 1'b0) begin errors++; $display("[TB] FAIL b2bSat[%0d]: got %b expected 0", i, sat); end
            checks++; if (readyB !== 1'b1) begin errors++; $display("[TB] FAIL b2bReady[%0d]: got %b expected 1", i, readyB); end
        end
    endtask

    task automatic test_rounding();
        int got;
        int lat;
        bit sat;
        bit satExp;
        int exp;
        int inputs [2] = '{3, -3};
        int outputs [2] = '{2, -1};
        applyReset();
        writeCoefB(0, 128);
        for (int i = 0; i < 2; i++) begin
            exp = modelStep(inputs[i], satExp);
            runSampleB(inputs[i], got, sat, lat);
            checks++; if (got !== outputs[i]) begin errors++; $display("[TB] FAIL rounding[%0d]: got %0d expected %0d", i, got, outputs[i]); end
        end
    endtask

    task automatic test_saturation();
        int got;
        int lat;
        bit sat;
        bit satExp;
        int exp;
        int sample;
        applyReset();
        for (int i = 0; i < TAPS_B; i++) writeCoefB(i, 32767);
        for (int i = 0; i < 8; i++) begin
            sample = (i < 4) ? 32767 : -32768;
            exp = modelStep(sample, satExp);
            runSampleB(sample, got, sat, lat);
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL satValue[%0d]: got %0d expected %0d", i, got, exp); end
            checks++; if (sat !== satExp) begin errors++; $display("[TB] FAIL satFlag[%0d]: got %b expected %b", i, sat, satExp); end
            if (i == 3) begin
                checks++; if (got !== 32767 || sat !== 1'b1) begin errors++; $display("[TB] FAIL satPos: got %0d/%b expected 32767/1", got, sat); end
            end
            if (i == 7) begin
                checks++; if (got !== -32768 || sat !== 1'b1) begin errors++; $display("[TB] FAIL satNeg: got %0d/%b expected -32768/1", got, sat); end
            end
        end
    endtask

    // A coefficient write together with a sample is used by that sample.
    task automatic test_coef_with_valid();
        int got;
        int lat;
        bit sat;
        bit satExp;
        int exp;
        applyReset();
        exp = modelStep(1200, satExp);
        weB = 1'b1; addrB = 2'd1; dataB = 16'sd512;
        coefM[1] = 512;
        exp = modelStep(-700, satExp);
        runSampleB(1200, got, sat, lat);
        runSampleB(-700, got, sat, lat);
        checks++; if (got !== exp) begin errors++; $display("[TB] FAIL coefWithValid: got %0d expected %0d", got, exp); end
    endtask

    task automatic test_random();
        int got;
        int lat;
        bit sat;
        bit satExp;
        int exp;
        int sample;
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < TAPS_B; i++) writeCoefB(i, int'($urandom_range(0, 800)) - 400);
            for (int n = 0; n < 10; n++) begin
                sample = int'($urandom_range(0, 65535)) - 32768;
                exp = modelStep(sample, satExp);
                runSampleB(sample, got, sat, lat);
                checks++; if (got !== exp || sat !== satExp) begin errors++; $display("[TB] FAIL random[%0d.%0d]: got %0d/%b expected %0d/%b (in %0d)", round, n, got, sat, exp, satExp, sample); end
                checks++; if (lat !== TAPS_B + 1) begin errors++; $display("[TB] FAIL randomLatency[%0d.%0d]: got %0d expected %0d", round, n, lat, TAPS_B + 1); end
            end
        end
    endtask

    // A sample (v=0) or coefficient write (v=1) offered mid-MAC is dropped.
    task automatic test_overrun();
        int got;
        int lat;
        bit sat;
        bit satExp;
        int exp;
        bit done;
        int k = 3;
        for (int v = 0; v < 2; v++) begin
            exp = modelStep(2500 + v, satExp);
            audioB = 16'(2500 + v);
            validB = 1'b1;
            @(posedge clk);
            #1 validB = 1'b0;
            done = 1'b0; got = 0;
            for (int e = 1; e <= TAPS_B + 8; e++) begin
                if (!done) begin
                    @(posedge clk);
                    #1;
                    if (e == k) begin
                        validB = 1'b0;
                        weB    = 1'b0;
                        checks++; if (overrunB !== 1'b1) begin errors++; $display("[TB] FAIL overrunPulse[%0d]: got %b expected 1", v, overrunB); end
                    end
                    if (e == k + 1) begin
                        checks++; if (overrunB !== 1'b0) begin errors++; $display("[TB] FAIL overrunClear[%0d]: got %b expected 0", v, overrunB); end
                    end
                    if (e == k - 1) begin
                        if (v == 0) begin
                            validB = 1'b1; audioB = 16'sd7777;
                        end else begin
                            weB = 1'b1; addrB = 2'd1; dataB = 16'sd12345;
                        end
                    end
                    if (dataReadyB) begin
                        done = 1'b1;
                        got  = int'(filtB);
                    end
                end
            end
            checks++; if (!done || got !== exp) begin errors++; $display("[TB] FAIL overrunResult[%0d]: got %0d (done %b) expected %0d", v, got, done, exp); end
            exp = modelStep(-1800, satExp);
            runSampleB(-1800, got, sat, lat);
            checks++; if (got !== exp) begin errors++; $display("[TB] FAIL overrunAfter[%0d]: got %0d expected %0d", v, got, exp); end
        end
    endtask

    task automatic test_reset_mid_mac();
        int got;
        int lat;
        bit sat;
        bit satExp;
        int exp;
        int pulses;
        audioB = 16'sd4321;
        validB = 1'b1;
        @(posedge clk);
        #1 validB = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (readyB !== 1'b1 || filtB !== 16'sd0) begin errors++; $display("[TB] FAIL midResetState: got ready %b filt %0d expected 1/0", readyB, filtB); end
        @(posedge clk);
        #1 rst = 1'b0;
        modelReset();
        pulses = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            #1;
            if (dataReadyB) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL abortedSample: got %0d data_ready pulses expected 0", pulses); end
        for (int i = 1; i < TAPS_B; i++) writeCoefB(i, 256);
        exp = modelStep(1000, satExp);
        runSampleB(1000, got, sat, lat);
        checks++; if (got !== 1000) begin errors++; $display("[TB] FAIL afterReset: got %0d expected 1000", got); end
        checks++; if (lat !== TAPS_B + 1) begin errors++; $display("[TB] FAIL afterResetLatency: got %0d expected %0d", lat, TAPS_B + 1); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        test_reset();
        test_default_latency();
        test_back_to_back();
        test_rounding();
        test_saturation();
        test_coef_with_valid();
        test_random();
        test_overrun();
        test_reset_mid_mac();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
